// File: rtl/proc_imm_pkg.sv
// Shared immediate formats, RV opcodes and shift funct3 codes
// for the proc datapath immediate generator.
package proc_imm_pkg;

    typedef enum logic [2:0] {
        IMM_I     = 3'd0,
        IMM_S     = 3'd1,
        IMM_B     = 3'd2,
        IMM_U     = 3'd3,
        IMM_J     = 3'd4,
        IMM_Z     = 3'd5,
        IMM_SHAMT = 3'd6,
        IMM_ILL   = 3'd7
    } imm_type_e;

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_SLLI = 3'b001;
    localparam logic [2:0] F3_SRLI = 3'b101;

endpackage

// File: rtl/proc_dpath_imm_gen_pipe_decode.sv
// Combinational immediate extraction: picks a format (explicit or
// opcode-decoded) and extends the immediate to p_xlen.
module proc_imm_decode
    import proc_imm_pkg::*;
#(
    parameter int p_xlen = 32,
    parameter bit p_auto = 1'b0
) (
    input  logic [31:0]       inst,
    input  logic [2:0]        sel,
    output logic [p_xlen-1:0] imm,
    output logic [2:0]        fmt,
    output logic              err
);

    logic [6:0]         opc;
    logic [2:0]         f3;
    imm_type_e          auto_fmt;
    imm_type_e          cur;
    logic signed [31:0] sv;

    assign opc = inst[6:0];
    assign f3  = inst[14:12];

    always_comb begin
        auto_fmt = IMM_ILL;
        case (opc)
            OPC_OPIMM: begin
                if (f3 == F3_SLLI || f3 == F3_SRLI) auto_fmt = IMM_SHAMT;
                else auto_fmt = IMM_I;
            end
            OPC_LOAD, OPC_JALR:  auto_fmt = IMM_I;
            OPC_STORE:           auto_fmt = IMM_S;
            OPC_BRANCH:          auto_fmt = IMM_B;
            OPC_LUI, OPC_AUIPC:  auto_fmt = IMM_U;
            OPC_JAL:             auto_fmt = IMM_J;
            OPC_SYSTEM: begin
                // ecall/ebreak (funct3 000) carry no usable immediate
                if (f3[2]) auto_fmt = IMM_Z;
                else if (f3 != 3'b000) auto_fmt = IMM_I;
            end
            default: auto_fmt = IMM_ILL;
        endcase
    end

    always_comb begin
        if (p_auto) cur = auto_fmt;
        else cur = imm_type_e'(sel);

        unique case (cur)
            IMM_I: sv = {{20{inst[31]}}, inst[31:20]};
            IMM_S: sv = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B: sv = {{19{inst[31]}}, inst[31], inst[7],
                         inst[30:25], inst[11:8], 1'b0};
            IMM_U: sv = {inst[31:12], 12'b0};
            IMM_J: sv = {{11{inst[31]}}, inst[31], inst[19:12],
                         inst[20], inst[30:21], 1'b0};
            default: sv = '0;
        endcase

        // signed cast carries the sign through to the full width
        imm = p_xlen'(sv);
        if (cur == IMM_Z) imm = p_xlen'(inst[19:15]);
        if (cur == IMM_SHAMT) begin
            if (p_xlen == 64) imm = p_xlen'(inst[25:20]);
            else imm = p_xlen'(inst[24:20]);
        end

        fmt = cur;
        err = (cur == IMM_ILL);
    end

endmodule

// File: rtl/proc_dpath_imm_gen_pipe.sv
// Pipelined immediate generator: decode at accept time, then a
// 2-entry skid buffer between the val/rdy streams.
module proc_dpath_imm_gen_pipe
    import proc_imm_pkg::*;
#(
    parameter int p_xlen  = 32,
    parameter bit p_auto  = 1'b0,
    parameter int p_tag_w = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_val,
    output logic               in_rdy,
    input  logic [31:0]        in_inst,
    input  logic [2:0]         in_imm_type,
    input  logic [p_tag_w-1:0] in_tag,
    output logic               out_val,
    input  logic               out_rdy,
    output logic [p_xlen-1:0]  out_imm,
    output logic [2:0]         out_type,
    output logic               out_err,
    output logic [p_tag_w-1:0] out_tag
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]         state;
    logic [1:0]         state_nx;
    logic               rdy_q;
    logic               accept;
    logic               drain;

    logic [p_xlen-1:0]  dec_imm;
    logic [2:0]         dec_fmt;
    logic               dec_err;

    logic [p_xlen-1:0]  skid_imm;
    logic [2:0]         skid_type;
    logic               skid_err;
    logic [p_tag_w-1:0] skid_tag;

    logic               load_in;
    logic               load_skid;
    logic               pop_skid;

    proc_imm_decode #(
        .p_xlen (p_xlen),
        .p_auto (p_auto)
    ) u_dec (
        .inst (in_inst),
        .sel  (in_imm_type),
        .imm  (dec_imm),
        .fmt  (dec_fmt),
        .err  (dec_err)
    );

    // reset gating keeps the handshake quiet during the reset cycle
    assign in_rdy  = rdy_q && !reset;
    assign out_val = (state != ST_EMPTY) && !reset;
    assign accept  = in_val && in_rdy;
    assign drain   = out_val && out_rdy;

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_EMPTY: if (accept) state_nx = ST_ONE;
            ST_ONE: begin
                if (accept && !drain) state_nx = ST_TWO;
                else if (drain && !accept) state_nx = ST_EMPTY;
            end
            ST_TWO: if (drain) state_nx = ST_ONE;
            default: state_nx = ST_EMPTY;
        endcase
    end

    assign load_in   = accept && ((state == ST_EMPTY) ||
                                  (state == ST_ONE && drain));
    assign load_skid = accept && (state == ST_ONE) && !drain;
    assign pop_skid  = drain && (state == ST_TWO);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_EMPTY;
            rdy_q     <= 1'b1;
            out_imm   <= '0;
            out_type  <= '0;
            out_err   <= 1'b0;
            out_tag   <= '0;
            skid_imm  <= '0;
            skid_type <= '0;
            skid_err  <= 1'b0;
            skid_tag  <= '0;
        end else begin
            state <= state_nx;
            rdy_q <= (state_nx != ST_TWO);
            if (load_in) begin
                out_imm  <= dec_imm;
                out_type <= dec_fmt;
                out_err  <= dec_err;
                out_tag  <= in_tag;
            end else if (pop_skid) begin
                out_imm  <= skid_imm;
                out_type <= skid_type;
                out_err  <= skid_err;
                out_tag  <= skid_tag;
            end
            if (load_skid) begin
                skid_imm  <= dec_imm;
                skid_type <= dec_fmt;
                skid_err  <= dec_err;
                skid_tag  <= in_tag;
            end
        end
    end

endmodule

// File: tb/tb_proc_dpath_imm_gen_pipe.sv
// Directed bench: three configurations share one stimulus stream
// (xlen32/explicit, xlen32/auto, xlen64/auto).
module tb_proc_dpath_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_val;
    logic        out_rdy;
    logic [31:0] in_inst;
    logic [2:0]  in_imm_type;
    logic [7:0]  in_tag;

    logic        a_rdy, a_val, a_err;
    logic [31:0] a_imm;
    logic [2:0]  a_type;
    logic [7:0]  a_tag;

    logic        b_rdy, b_val, b_err;
    logic [31:0] b_imm;
    logic [2:0]  b_type;
    logic [7:0]  b_tag;

    logic        c_rdy, c_val, c_err;
    logic [63:0] c_imm;
    logic [2:0]  c_type;
    logic [7:0]  c_tag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    proc_dpath_imm_gen_pipe #(.p_xlen(32), .p_auto(1'b0), .p_tag_w(8)) dut_a (
        .clk (clk), .reset (reset),
        .in_val (in_val), .in_rdy (a_rdy), .in_inst (in_inst),
        .in_imm_type (in_imm_type), .in_tag (in_tag),
        .out_val (a_val), .out_rdy (out_rdy), .out_imm (a_imm),
        .out_type (a_type), .out_err (a_err), .out_tag (a_tag)
    );

    proc_dpath_imm_gen_pipe #(.p_xlen(32), .p_auto(1'b1), .p_tag_w(8)) dut_b (
        .clk (clk), .reset (reset),
        .in_val (in_val), .in_rdy (b_rdy), .in_inst (in_inst),
        .in_imm_type (in_imm_type), .in_tag (in_tag),
        .out_val (b_val), .out_rdy (out_rdy), .out_imm (b_imm),
        .out_type (b_type), .out_err (b_err), .out_tag (b_tag)
    );

    proc_dpath_imm_gen_pipe #(.p_xlen(64), .p_auto(1'b1), .p_tag_w(8)) dut_c (
        .clk (clk), .reset (reset),
        .in_val (in_val), .in_rdy (c_rdy), .in_inst (in_inst),
        .in_imm_type (in_imm_type), .in_tag (in_tag),
        .out_val (c_val), .out_rdy (out_rdy), .out_imm (c_imm),
        .out_type (c_type), .out_err (c_err), .out_tag (c_tag)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] inst, input logic [2:0] t,
                        input logic [7:0] tag);
        in_val      = 1'b1;
        in_inst     = inst;
        in_imm_type = t;
        in_tag      = tag;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        in_val      = 1'b0;
        out_rdy     = 1'b0;
        in_inst     = '0;
        in_imm_type = '0;
        in_tag      = '0;

        tick();
        chk("rst_in_rdy", a_rdy, 0);
        chk("rst_out_val", a_val, 0);
        tick();
        reset = 1'b0;
        #1;
        chk("post_rst_in_rdy", a_rdy, 1);
        chk("post_rst_out_val", a_val, 0);
        chk("post_rst_imm", a_imm, 0);
        chk("post_rst_type", a_type, 0);
        chk("post_rst_err", a_err, 0);
        chk("post_rst_tag", a_tag, 0);
        chk("post_rst_c_val", c_val, 0);

        // formats, one per cycle with the sink always ready
        out_rdy = 1'b1;
        send(32'hFFF00093, 3'd0, 8'h11);
        tick();
        chk("i_val", a_val, 1);
        chk("i_imm_a", a_imm, 64'hFFFFFFFF);
        chk("i_err_a", a_err, 0);
        chk("i_tag_a", a_tag, 8'h11);
        chk("i_type_b", b_type, 0);
        chk("i_imm_b", b_imm, 64'hFFFFFFFF);
        chk("i_imm_c", c_imm, 64'hFFFFFFFFFFFFFFFF);

        send(32'hFE000EE3, 3'd2, 8'h12);
        tick();
        chk("b_type_b", b_type, 2);
        chk("b_imm_b", b_imm, 64'hFFFFFFFC);
        chk("b_imm_a", a_imm, 64'hFFFFFFFC);
        chk("b_imm_c", c_imm, 64'hFFFFFFFFFFFFFFFC);
        chk("b_tag_b", b_tag, 8'h12);

        send(32'h0000007F, 3'd7, 8'h13);
        tick();
        chk("ill_type_b", b_type, 7);
        chk("ill_err_b", b_err, 1);
        chk("ill_imm_b", b_imm, 0);
        chk("ill_err_a", a_err, 1);
        chk("ill_imm_c", c_imm, 0);

        send(32'h80000037, 3'd3, 8'h14);
        tick();
        chk("u_imm_c", c_imm, 64'hFFFFFFFF80000000);
        chk("u_type_c", c_type, 3);
        chk("u_err_c", c_err, 0);
        chk("u_imm_a", a_imm, 64'h80000000);

        send(32'h03F09093, 3'd6, 8'h15);
        tick();
        chk("sh_type_c", c_type, 6);
        chk("sh_imm_c", c_imm, 64'h3F);
        chk("sh_imm_b", b_imm, 64'h1F);
        chk("sh_imm_a", a_imm, 64'h1F);

        send(32'h000FD073, 3'd5, 8'h16);
        tick();
        chk("z_type_b", b_type, 5);
        chk("z_imm_b", b_imm, 64'h1F);
        chk("z_imm_a", a_imm, 64'h1F);

        send(32'hFE112E23, 3'd1, 8'h17);
        tick();
        chk("s_type_b", b_type, 1);
        chk("s_imm_a", a_imm, 64'hFFFFFFFC);
        chk("s_imm_c", c_imm, 64'hFFFFFFFFFFFFFFFC);

        send(32'h0080006F, 3'd4, 8'h18);
        tick();
        chk("j_type_c", c_type, 4);
        chk("j_imm_c", c_imm, 64'h8);
        chk("j_imm_a", a_imm, 64'h8);

        in_val = 1'b0;
        tick();
        chk("drain_empty", a_val, 0);

        // backpressure: fill both entries, third request must wait
        out_rdy = 1'b0;
        send(32'h00100093, 3'd0, 8'd1);
        tick();
        chk("bp1_rdy", a_rdy, 1);
        chk("bp1_val", a_val, 1);
        chk("bp1_tag", a_tag, 1);
        send(32'h00200093, 3'd0, 8'd2);
        tick();
        chk("bp2_rdy", a_rdy, 0);
        chk("bp2_tag", a_tag, 1);
        chk("bp2_imm", a_imm, 1);
        send(32'h00300093, 3'd0, 8'd3);
        tick();
        chk("bp3_rdy", a_rdy, 0);
        chk("bp3_hold_tag", a_tag, 1);
        out_rdy = 1'b1;
        tick();
        chk("bp_out2_val", a_val, 1);
        chk("bp_out2_tag", a_tag, 2);
        chk("bp_out2_imm", a_imm, 2);
        chk("bp_out2_rdy", a_rdy, 1);
        tick();
        chk("bp_out3_val", a_val, 1);
        chk("bp_out3_tag", a_tag, 3);
        chk("bp_out3_imm", a_imm, 3);
        in_val = 1'b0;
        tick();
        chk("bp_done_val", a_val, 0);

        // reset while the buffer holds two entries
        out_rdy = 1'b0;
        send(32'h00400093, 3'd0, 8'd4);
        tick();
        send(32'h00500093, 3'd0, 8'd5);
        tick();
        chk("mr_full_rdy", a_rdy, 0);
        chk("mr_full_val", a_val, 1);
        send(32'h00600093, 3'd0, 8'd6);
        reset = 1'b1;
        #1;
        chk("mr_rst_val", a_val, 0);
        chk("mr_rst_rdy", a_rdy, 0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        in_val = 1'b0;
        #1;
        chk("mr_after_rdy", a_rdy, 1);
        chk("mr_after_val", a_val, 0);
        chk("mr_after_tag", a_tag, 0);
        chk("mr_after_imm", a_imm, 0);
        out_rdy = 1'b1;
        tick();
        chk("mr_no_stale", a_val, 0);
        tick();
        chk("mr_no_stale2", a_val, 0);

        // throughput: one result per cycle after one cycle of latency
        for (int i = 0; i < 16; i++) begin
            send((32'(i) << 20) | 32'h93, 3'd0, 8'(8'h20 + i));
            tick();
            chk("tp_val", a_val, 1);
            chk("tp_tag", a_tag, 64'(8'h20 + i));
            chk("tp_imm", a_imm, 64'(i));
            chk("tp_rdy", a_rdy, 1);
        end
        in_val = 1'b0;
        tick();
        chk("tp_end_val", a_val, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/proc_dpath_imm_gen_pipe.md
Name: proc_dpath_imm_gen_pipe

Overview:
- Pipelined, parametrised immediate generator for the proc datapath, placed between fetch/decode and the operand muxes.
- Accepts instructions on a val/rdy stream and extracts and extends the immediate to p_xlen.
- Formats come either from an explicit imm_type or from opcode decode (auto mode).
- A 2-entry skid buffer decouples the upstream and downstream handshakes at full throughput.

Parameters:
p_xlen, 32, output width; legal values 32 or 64
p_auto, 0, 0 = use in_imm_type; 1 = derive format from inst opcode/funct3
p_tag_w, 8, width of opaque tag carried alongside each instruction

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
in_val  input  1  upstream transaction valid
in_rdy  output  1  block can accept (registered)
in_inst  input  32  instruction word
in_imm_type  input  3  format select (ignored when p_auto=1)
in_tag  input  p_tag_w  opaque tag
out_val  output  1  output transaction valid
out_rdy  input  1  downstream accepts
out_imm  output  p_xlen  extended immediate
out_type  output  3  format actually used
out_err  output  1  illegal format/opcode
out_tag  output  p_tag_w  tag of this transaction

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, named reset.
- Formats (3-bit codes):
  - 0 I: sext inst[31:20]
  - 1 S: sext {inst[31:25],inst[11:7]}
  - 2 B: sext {inst[31],inst[7],inst[30:25],inst[11:8],0}
  - 3 U: sext {inst[31:12],12'b0}
  - 4 J: sext {inst[31],inst[19:12],inst[20],inst[30:21],0}
  - 5 Z: zext inst[19:15]
  - 6 SHAMT: zext inst[24:20] (p_xlen=32) or inst[25:20] (p_xlen=64)
  - 7 illegal: imm=0, err=1
- Extension rules: sign extension always goes to the full p_xlen. Fill bits are always 0, never X/Z.
- Auto decode (p_auto=1):
  - 0010011 with funct3 001/101 -> SHAMT
  - Other 0010011, 0000011, 1100111 -> I
  - 0100011 -> S; 1100011 -> B; 0110111/0010111 -> U; 1101111 -> J
  - 1110011 with funct3[2]=1 -> Z
  - 1110011 with funct3 in {001,010,011} -> I
  - Anything else -> 7 (err=1)
- Transfer rules: upstream transfer on in_val&&in_rdy; downstream transfer on out_val&&out_rdy.
- Latency: 1 cycle. A transaction accepted in cycle N is presented in cycle N+1 if the buffer was empty.
- Buffer FSM: EMPTY, ONE, TWO.
  - EMPTY: accept -> ONE.
  - ONE: accept without drain -> TWO; drain without accept -> EMPTY; accept and drain -> ONE.
  - TWO: drain -> ONE. No accept is possible in TWO.
- in_rdy = (state != TWO), driven from a register. Strict FIFO order.
- Output data registers hold stable while out_val && !out_rdy.
- Reset (including mid-operation): state -> EMPTY, out_val=0, out_imm/out_type/out_err/out_tag=0, in_rdy=0 during the reset cycle and 1 in the following cycle. In-flight transactions are discarded.
- in_val asserted while reset is high is ignored.
- The immediate is computed combinationally from in_inst at accept time and stored. Later changes to in_inst do not affect stored entries.

Decomposition:
- Package proc_imm_pkg holds:
  - the imm_type enum (IMM_I..IMM_ILL)
  - opcode localparams (OPC_OPIMM, OPC_LOAD, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_SYSTEM)
  - funct3 constants for shifts
- One combinational sub-module, proc_imm_decode (inst, imm_type, p_xlen, p_auto -> imm, type, err).
- The top level holds the 2-entry buffer and the FSM.

Test Plan:
- I-type: p_xlen=32, p_auto=0, type 0, inst 0xFFF00093, out_rdy=1 -> next cycle out_imm=0xFFFFFFFF, err=0.
- B-type auto decode: p_auto=1, inst 0xFE000EE3 -> out_type=2, out_imm=0xFFFFFFFC; inst 0x0000007F -> out_type=7, out_err=1, out_imm=0.
- U-type at 64 bits: p_xlen=64, p_auto=1, inst 0x80000037 -> out_imm=0xFFFFFFFF80000000. SHAMT check: inst 0x03F09093 -> out_type=6, out_imm=0x3F.
- Backpressure: out_rdy=0, present tags 1,2,3 back-to-back.
  - Tags 1 and 2 are accepted; in_rdy drops after the second accept; tag 3 is held.
  - Raise out_rdy: tags 1,2,3 are delivered in order, one per cycle, with no loss or duplication.
- Reset mid-operation: buffer in TWO, assert reset for one cycle -> out_val=0 and in_rdy=0 that cycle, in_rdy=1 next cycle, no stale entries emerge.
- Throughput: continuous in_val with out_rdy=1 for 16 instructions -> 16 outputs in 16 consecutive cycles after a 1-cycle latency.
